// File: rtl/uart_send_if.sv
// uart_send_if: byte request/status handshake between a byte producer and uart_send
//   tx_start      producer -> tx : send request, level-sampled while idle
//   tx_data       producer -> tx : byte to send, sampled on the accept edge
//   tx_busy       tx -> producer : frame in flight, requests ignored
//   tx_byte_done  tx -> producer : one-cycle pulse after the stop bit
interface uart_send_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_byte_done;
    modport master (output tx_start, tx_data, input tx_busy, tx_byte_done);
    modport slave (input tx_start, tx_data, output tx_busy, tx_byte_done);
endinterface

// File: rtl/uart_send.sv
// uart_send: 8N1 UART transmitter, one byte per accepted request, LSB first
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        uart_send_if.slave: tx_start/tx_data in, tx_busy/tx_byte_done out
//   uart_txd   serial line, idle high, driven straight from a flop
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD)
// between the data bits and the stop bit.
module uart_send #(
    parameter logic [15:0] BPS_CNT    = 16'd434,
    parameter logic        PARITY_ODD = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    uart_send_if.slave bus,
    output logic       uart_txd
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif
    if (BPS_CNT < 16'd2 || $bits(PARITY_ODD) != 1) begin : g_bad_cfg
        $error("uart_send: BPS_CNT must be at least 2");
    end
    assign bit_end          = clk_cnt_q == BPS_CNT - 16'd1;
    assign uart_txd         = txd_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_byte_done = done_q;
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q == IDLE) begin
            clk_cnt_d = 16'd0;
            if (bus.tx_start) begin
                // the start bit goes out on the accept edge itself
                state_d   = START;
                shift_d   = bus.tx_data;
                bit_cnt_d = 3'd0;
                txd_d     = 1'b0;
                busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                par_d     = ^bus.tx_data ^ PARITY_ODD;
`endif
            end
        end else begin
            clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                        txd_d     = shift_q[0];
                    end
                    DATA: begin
                        // shift_q[1] is the bit that lands in [0] after this shift
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
                            txd_d   = par_q;
`else
                            state_d = STOP;
                            txd_d   = 1'b1;
`endif
                        end else begin
                            txd_d = shift_q[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end
`endif
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
`ifdef UART_TX_PARITY_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) par_q <= 1'b0;
        else par_q <= par_d;
    end
`endif
endmodule
